conv_result_writer: RTL and testbench
=====================================

// Module: conv_result_writer
// PURPOSE
//  Sink end of the 2-D conv result path: takes each 3x3 conv result from the conv core
//  (flagged by done_conv) and writes it into the output image BRAM.
//  - Normalises each result to an 8-bit pixel and writes it at its raster address.
//  - Counts written pixels and raises done once IMG_W*IMG_H pixels are stored.
//  - Sits between the conv core and the output BRAM and replaces file dumping in hardware.
// PARAMETERS
//  IMG_W   128  output image width in pixels
//  IMG_H   128  output image height in pixels
//  RES_W   24   conv result width, two's complement
//  PIX_W   8    output pixel width
//  ADDR_W  14   output BRAM address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
//  SHIFT   0    arithmetic right shift applied to result before saturation
//  SKIP    0    number of leading done_conv events discarded (conv pipeline priming)
// PORTS
//  clk        in   1       clock; all logic on rising edge
//  rst_n      in   1       synchronous reset, active-low
//  start      in   1       arm/restart writer; clears counters
//  done_conv  in   1       conv result valid; may stay high >1 cycle, rising edge = one result
//  result     in   RES_W   conv result; stable while done_conv is high
//  we_bram    out  1       output BRAM write enable, 1-cycle pulse per pixel
//  addr_bram  out  ADDR_W  output BRAM write address (raster order, row*IMG_W+col)
//  din_bram   out  PIX_W   output BRAM write data
//  busy       out  1       high in ARMED or WRITE
//  done       out  1       whole image written; held until start or reset
//  clip_cnt   out  ADDR_W+1  number of pixels saturated (low or high) this frame
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE.
//   - we_bram=0, addr_bram=0, din_bram=0, busy=0, done=0, clip_cnt=0.
//   - Skip counter=0; done_conv edge register=0.
//   - Reset mid-frame aborts with no further writes.
//  Event detection: ev = done_conv & ~done_conv_q; done_conv_q is registered every cycle, all states.
//  FSM:
//   - IDLE: start -> ARMED; addr/clip_cnt/skip cleared.
//   - ARMED: on ev, if skip<SKIP then skip++ and nothing is written;
//     else latch result -> WRITE.
//   - WRITE: one cycle with we_bram=1, addr_bram=current pixel index, din_bram=sat(result).
//     - If index==IMG_W*IMG_H-1 -> DONE; else index++, -> ARMED.
//   - DONE: done=1, busy=0; ev ignored; start -> ARMED with counters cleared, done dropped.
//  Latency: ev sampled at edge E -> we_bram high in cycle E+1 only.
//   - Back-to-back ev at E and E+2 are both written (min done_conv period 2 cycles).
//   - An ev arriving while in WRITE is dropped (not an error; producer guarantees spacing).
//  Saturation: v = $signed(result) >>> SHIFT.
//   - v<0 -> 0; v>2**PIX_W-1 -> 2**PIX_W-1; else v[PIX_W-1:0].
//   - clip_cnt++ on every write that clipped; saturates at all-ones.
//  start priority: start in any state restarts to ARMED (from IDLE/ARMED/WRITE/DONE).
//   - An ev in the same cycle as start is discarded.
//   - A WRITE in progress in that cycle is suppressed (we_bram=0).
//  we_bram is 0 in every state except WRITE; addr_bram/din_bram hold their last value between writes.
//  done rises in the cycle after the last WRITE and stays high; it is never high together with we_bram.
// TESTING
//  T1 reset: rst_n=0 for 3 clks with done_conv toggling -> all outputs 0, no we_bram.
//  T2 start, 4 events result=0x000050,0x0000FF,0x000100,0xFFFF00 (SHIFT=0)
//     -> writes addr 0..3, data 0x50,0xFF,0xFF,0x00; clip_cnt=2.
//  T3 SHIFT=4, result=0x000800 -> din_bram=0x80.
//     - done_conv held high 5 cycles -> exactly one write.
//  T4 SKIP=2: 3 events -> only 3rd written, at addr 0.
//  T5 full frame of 16384 events with result=index&0xFF
//     -> last write addr 0x3FFF, done=1 next cycle, further events ignored.
//  T6 start asserted at pixel 100 together with ev
//     -> no write that cycle, next ev written at addr 0; done=0.
//     - Repeat with rst_n=0 mid-frame -> IDLE.

Source files
------------

// File: rtl/conv_result_writer.sv
// Sink end of the 2-D conv result path: saturates each conv result to a pixel and writes it
// into the output image BRAM in raster order, flagging done once the whole frame is stored.
module conv_result_writer #(
  parameter int unsigned IMG_W  = 128,
  parameter int unsigned IMG_H  = 128,
  parameter int unsigned RES_W  = 24,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned SHIFT  = 0,
  parameter int unsigned SKIP   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              done_conv,
  input  logic [RES_W-1:0]  result,
  output logic              we_bram,
  output logic [ADDR_W-1:0] addr_bram,
  output logic [PIX_W-1:0]  din_bram,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   clip_cnt
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);
  localparam int unsigned SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_N = SKIP_W'(SKIP);

  typedef enum logic [1:0] {StIdle, StArmed, StWrite, StDone} state_e;

  state_e state_q, state_d;

  logic                    dc_q;
  logic                    ev;
  logic [SKIP_W-1:0]       skip_q;
  logic [ADDR_W-1:0]       idx_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [PIX_W-1:0]        din_q;
  logic                    clip_flag_q;
  logic [ADDR_W:0]         clip_cnt_q;
  logic signed [RES_W-1:0] shifted;
  logic [PIX_W-1:0]        sat;
  logic                    clip;

  assign ev = done_conv & ~dc_q;

  // Sign bit set -> negative; any bit between PIX_W and the sign bit set -> above max.
  always_comb begin
    shifted = $signed(result) >>> SHIFT;
    sat     = shifted[PIX_W-1:0];
    clip    = 1'b0;
    if (shifted[RES_W-1]) begin
      sat  = '0;
      clip = 1'b1;
    end else if (|shifted[RES_W-2:PIX_W]) begin
      sat  = '1;
      clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StArmed;
    end else begin
      case (state_q)
        StIdle:  state_d = StIdle;
        StArmed: begin
          if (ev && (skip_q == SKIP_N)) state_d = StWrite;
        end
        StWrite: state_d = (idx_q == LAST_IDX) ? StDone : StArmed;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // A start landing on the write cycle cancels that write.
  always_comb begin
    we_bram = (state_q == StWrite) && !start;
    busy    = (state_q == StArmed) || (state_q == StWrite);
    done    = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dc_q        <= 1'b0;
      skip_q      <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      clip_flag_q <= 1'b0;
      clip_cnt_q  <= '0;
    end else begin
      dc_q <= done_conv;
      if (start) begin
        skip_q      <= '0;
        idx_q       <= '0;
        addr_q      <= '0;
        clip_flag_q <= 1'b0;
        clip_cnt_q  <= '0;
      end else begin
        case (state_q)
          StArmed: begin
            if (ev) begin
              if (skip_q != SKIP_N) begin
                skip_q <= skip_q + 1'b1;
              end else begin
                addr_q      <= idx_q;
                din_q       <= sat;
                clip_flag_q <= clip;
              end
            end
          end
          StWrite: begin
            if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
            if (clip_flag_q && !(&clip_cnt_q)) clip_cnt_q <= clip_cnt_q + 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign addr_bram = addr_q;
  assign din_bram  = din_q;
  assign clip_cnt  = clip_cnt_q;

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer: default, SHIFT=4 and SKIP=2 instances share stimulus;
// each step checks the relevant instance against hand-computed values.
module tb_conv_result_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        done_conv;
  logic [23:0] result;

  logic        we0, busy0, done0;
  logic [13:0] addr0;
  logic [7:0]  din0;
  logic [14:0] clip0;
  logic        we_s, busy_s, done_s;
  logic [13:0] addr_s;
  logic [7:0]  din_s;
  logic [14:0] clip_s;
  logic        we_k, busy_k, done_k;
  logic [13:0] addr_k;
  logic [7:0]  din_k;
  logic [14:0] clip_k;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_result_writer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done_conv(done_conv), .result(result),
    .we_bram(we0), .addr_bram(addr0), .din_bram(din0), .busy(busy0), .done(done0),
    .clip_cnt(clip0)
  );

  conv_result_writer #(.SHIFT(4)) u_dut_shift (
    .clk(clk), .rst_n(rst_n), .start(start), .done_conv(done_conv), .result(result),
    .we_bram(we_s), .addr_bram(addr_s), .din_bram(din_s), .busy(busy_s), .done(done_s),
    .clip_cnt(clip_s)
  );

  conv_result_writer #(.SKIP(2)) u_dut_skip (
    .clk(clk), .rst_n(rst_n), .start(start), .done_conv(done_conv), .result(result),
    .we_bram(we_k), .addr_bram(addr_k), .din_bram(din_k), .busy(busy_k), .done(done_k),
    .clip_cnt(clip_k)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle done_conv pulse; returns on the negedge of the cycle a write would occupy.
  task automatic send(input logic [23:0] r);
    @(negedge clk);
    result    = r;
    done_conv = 1'b1;
    @(negedge clk);
    done_conv = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int wcnt;
    int bad;
    rst_n     = 1'b0;
    start     = 1'b0;
    done_conv = 1'b0;
    result    = '0;

    // T1: reset with done_conv toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      done_conv = ~done_conv;
    end
    @(negedge clk);
    done_conv = 1'b0;
    chk("t1_we", we0, 0);
    chk("t1_addr", addr0, 0);
    chk("t1_din", din0, 0);
    chk("t1_busy", busy0, 0);
    chk("t1_done", done0, 0);
    chk("t1_clip", clip0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(24'h000050);
    chk("t1_idle_no_write", we0, 0);

    // T2 (default) and T4 (SKIP=2) on the same four events
    pulse_start();
    chk("t2_busy", busy0, 1);
    chk("t2_done", done0, 0);
    send(24'h000050);
    chk("t2_we0", we0, 1);
    chk("t2_addr0", addr0, 0);
    chk("t2_din0", din0, 8'h50);
    chk("t4_skip1", we_k, 0);
    send(24'h0000FF);
    chk("t2_addr1", addr0, 1);
    chk("t2_din1", din0, 8'hFF);
    chk("t4_skip2", we_k, 0);
    send(24'h000100);
    chk("t2_addr2", addr0, 2);
    chk("t2_din2", din0, 8'hFF);
    chk("t4_we", we_k, 1);
    chk("t4_addr", addr_k, 0);
    chk("t4_din", din_k, 8'hFF);
    send(24'hFFFF00);
    chk("t2_we3", we0, 1);
    chk("t2_addr3", addr0, 3);
    chk("t2_din3", din0, 8'h00);
    @(negedge clk);
    chk("t2_clip", clip0, 2);
    chk("t2_we_pulse", we0, 0);
    chk("t2_addr_hold", addr0, 3);

    // T3: SHIFT=4, done_conv held high for 5 cycles
    pulse_start();
    @(negedge clk);
    result    = 24'h000800;
    done_conv = 1'b1;
    wcnt      = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (we_s === 1'b1) wcnt++;
      if (k == 4) done_conv = 1'b0;
    end
    chk("t3_writes", wcnt, 1);
    chk("t3_din", din_s, 8'h80);
    chk("t3_addr", addr_s, 0);

    // T5: full frame
    pulse_start();
    bad = 0;
    for (int i = 0; i < 16384; i++) begin
      send(24'(i & 255));
      if (we0 !== 1'b1 || addr0 !== 14'(i) || din0 !== 8'(i & 255)) bad++;
    end
    chk("t5_stream_errs", bad, 0);
    chk("t5_last_addr", addr0, 14'h3FFF);
    chk("t5_not_done_yet", done0, 0);
    @(negedge clk);
    chk("t5_done", done0, 1);
    chk("t5_we_after", we0, 0);
    chk("t5_busy", busy0, 0);
    send(24'h000011);
    chk("t5_ev_ignored", we0, 0);
    chk("t5_done_held", done0, 1);

    // T6: restart with start coincident with ev at pixel 100
    pulse_start();
    chk("t6_done_dropped", done0, 0);
    for (int i = 0; i < 100; i++) send(24'h000001);
    chk("t6_addr99", addr0, 99);
    @(negedge clk);
    start     = 1'b1;
    done_conv = 1'b1;
    result    = 24'h000010;
    @(negedge clk);
    start     = 1'b0;
    done_conv = 1'b0;
    chk("t6_no_write", we0, 0);
    chk("t6_busy", busy0, 1);
    send(24'h000033);
    chk("t6_we", we0, 1);
    chk("t6_addr", addr0, 0);
    chk("t6_din", din0, 8'h33);
    chk("t6_done", done0, 0);
    // start during the write cycle suppresses it
    @(negedge clk);
    done_conv = 1'b1;
    result    = 24'h000044;
    @(negedge clk);
    done_conv = 1'b0;
    start     = 1'b1;
    #1;
    chk("t6_write_suppressed", we0, 0);
    @(negedge clk);
    start = 1'b0;
    send(24'h000055);
    chk("t6_after_suppress_addr", addr0, 0);
    chk("t6_after_suppress_din", din0, 8'h55);

    // Reset mid-frame
    send(24'h000066);
    send(24'h000077);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6r_we", we0, 0);
    chk("t6r_busy", busy0, 0);
    chk("t6r_addr", addr0, 0);
    chk("t6r_din", din0, 0);
    send(24'h000088);
    chk("t6r_idle_no_write", we0, 0);
    chk("t6r_idle_busy", busy0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
